// File: rtl/sha3_pkg.sv
// Shared SHA-3 digest-transmit definitions: mode encoding, per-mode word
// counts, output word width and the Keccak lane ordering of the digest.
package sha3_pkg;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned LANE_W    = 64;
    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned BUF_W     = NUM_LANES * LANE_W;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha3_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    // Full Keccak state, lane A[x][y] = state[x][y]
    typedef logic [0:4][0:4][LANE_W-1:0] keccak_state_t;

    localparam logic [CNT_W-1:0] WORDS_224 = 5'd14;
    localparam logic [CNT_W-1:0] WORDS_256 = 5'd16;
    localparam logic [CNT_W-1:0] WORDS_384 = 5'd24;
    localparam logic [CNT_W-1:0] WORDS_512 = 5'd32 - 5'd0; // 32 wraps to 0 in 5 bits; see last_word_idx

    // Digest lane order: lane L of the digest is A[LANE_X[L]][LANE_Y[L]]
    localparam int unsigned LANE_X [NUM_LANES] = '{0, 1, 2, 3, 4, 0, 1, 2};
    localparam int unsigned LANE_Y [NUM_LANES] = '{0, 0, 0, 0, 0, 1, 1, 1};

    // Index of the final word of a packet (word count minus one, fits 5 bits)
    function automatic logic [CNT_W-1:0] last_word_idx(input sha3_mode_t mode);
        case (mode)
            SHA3_224: last_word_idx = WORDS_224 - 5'd1;
            SHA3_256: last_word_idx = WORDS_256 - 5'd1;
            SHA3_384: last_word_idx = WORDS_384 - 5'd1;
            default:  last_word_idx = 5'd31;
        endcase
    endfunction

    // Lanes are little-endian; swapping the two bytes yields big-endian order
    function automatic logic [WIDTH-1:0] swap16(input logic [WIDTH-1:0] half);
        swap16 = {half[7:0], half[15:8]};
    endfunction

endpackage

// File: rtl/sha_digest_tx_if.sv
// Handshake bundle for sha_digest_tx: Keccak state input side and the
// AXI-Stream style digest output side.
//   slave  : view of the digest transmitter
//   master : view of the surrounding logic (state source + stream sink)
interface sha_digest_tx_if;
    import sha3_pkg::*;

    keccak_state_t      state_in;
    logic               state_valid;
    logic               state_ready;
    logic [1:0]         ID;
    logic [WIDTH-1:0]   M_TDATA;
    logic               M_TVALID;
    logic               M_TREADY;
    logic               M_TLAST;
    logic               busy;

    modport slave (
        input  state_in, state_valid, ID, M_TREADY,
        output state_ready, M_TDATA, M_TVALID, M_TLAST, busy
    );

    modport master (
        output state_in, state_valid, ID, M_TREADY,
        input  state_ready, M_TDATA, M_TVALID, M_TLAST, busy
    );
endinterface

// File: rtl/sha_word_sel.sv
// Combinational digest word selector.
//   lanes : 512-bit digest buffer, lane L at bits [64L+63:64L]
//   idx   : word index k
//   word  : big-endian 16-bit word k of the digest
module sha_word_sel
    import sha3_pkg::*;
(
    input  logic [BUF_W-1:0] lanes,
    input  logic [CNT_W-1:0] idx,
    output logic [WIDTH-1:0] word
);
    logic [LANE_W-1:0] lane;
    logic [WIDTH-1:0]  half;

    // Four words per lane: idx[4:2] picks the lane, idx[1:0] the 16-bit slice
    always_comb begin
        lane = lanes[{idx[4:2], 6'd0} +: LANE_W];
        half = lane[{idx[1:0], 4'd0} +: WIDTH];
        word = swap16(half);
    end
endmodule

// File: rtl/sha_digest_tx.sv
// Streams a SHA-3 digest taken from the final Keccak state as 16-bit words.
//   ACLK   : clock
//   ARESET : asynchronous active-high reset
//   bus    : state_in/state_valid/state_ready/ID in, M_T* stream out, busy
module sha_digest_tx
    import sha3_pkg::*;
(
    input  logic          ACLK,
    input  logic          ARESET,
    sha_digest_tx_if.slave bus
);
    tx_state_t          state;
    sha3_mode_t         id;
    logic [CNT_W-1:0]   cnt;
    logic [BUF_W-1:0]   buffer;
    logic [BUF_W-1:0]   capture_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic [CNT_W-1:0]   last_idx_c;
    logic [WIDTH-1:0]   word_nxt_c;

    // Gather the eight digest lanes out of the Keccak state
    always_comb begin
        capture_c = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            capture_c[l*LANE_W +: LANE_W] = bus.state_in[LANE_X[l]][LANE_Y[l]];
        end
    end

    assign cnt_inc_c  = cnt + CNT_W'(1);
    assign last_idx_c = last_word_idx(id);

    // Look one word ahead so M_TDATA can be registered
    sha_word_sel u_word_sel (
        .lanes (buffer),
        .idx   (cnt_inc_c),
        .word  (word_nxt_c)
    );

    // Transmit FSM with registered handshake and data outputs
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state           <= ST_IDLE;
            id              <= SHA3_224;
            cnt             <= '0;
            buffer          <= '0;
            bus.state_ready <= 1'b0;
            bus.M_TVALID    <= 1'b0;
            bus.M_TLAST     <= 1'b0;
            bus.M_TDATA     <= '0;
            bus.busy        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.state_ready <= 1'b1;
                    if (bus.state_valid && bus.state_ready) begin
                        state           <= ST_SEND;
                        id              <= sha3_mode_t'(bus.ID);
                        cnt             <= '0;
                        buffer          <= capture_c;
                        bus.state_ready <= 1'b0;
                        bus.M_TVALID    <= 1'b1;
                        bus.busy        <= 1'b1;
                        // Shortest packet is 14 words, so word 0 is never last
                        bus.M_TLAST     <= 1'b0;
                        bus.M_TDATA     <= swap16(capture_c[WIDTH-1:0]);
                    end
                end
                ST_SEND: begin
                    if (bus.M_TREADY) begin
                        if (cnt == last_idx_c) begin
                            state           <= ST_IDLE;
                            cnt             <= '0;
                            bus.state_ready <= 1'b1;
                            bus.M_TVALID    <= 1'b0;
                            bus.M_TLAST     <= 1'b0;
                            bus.busy        <= 1'b0;
                        end else begin
                            cnt         <= cnt_inc_c;
                            bus.M_TDATA <= word_nxt_c;
                            bus.M_TLAST <= (cnt_inc_c == last_idx_c);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha_digest_tx.sv
// Self-checking bench for sha_digest_tx: known SHA3-256 vector, all modes,
// backpressure, ignored state_valid, mid-packet reset and back-to-back accept.
module tb_sha_digest_tx;
    import sha3_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] got_words[$];
    bit          got_last[$];
    logic [15:0] exp_words[$];
    int          stab_err;
    bit          timed_out;

    sha_digest_tx_if bus ();

    sha_digest_tx dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic keccak_state_t rand_state();
        keccak_state_t st;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                st[x][y] = {$urandom, $urandom};
        return st;
    endfunction

    // Reference: digest is the byte stream of lanes 0.. (lane L = A[L%5][L/5],
    // bytes little-endian within a lane), cut into big-endian 16-bit words.
    task automatic make_expected(input keccak_state_t st, input int id);
        int          nbits;
        logic [7:0]  bytes [64];
        logic [63:0] lane;
        nbits = (id == 0) ? 224 : (id == 1) ? 256 : (id == 2) ? 384 : 512;
        for (int j = 0; j < 64; j++) begin
            lane     = st[(j / 8) % 5][(j / 8) / 5];
            bytes[j] = lane[8 * (j % 8) +: 8];
        end
        exp_words.delete();
        for (int k = 0; k < nbits / 16; k++)
            exp_words.push_back({bytes[2 * k], bytes[2 * k + 1]});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_state(input keccak_state_t st, input logic [1:0] id, output bit ok);
        ok              = 1'b0;
        bus.state_in    = st;
        bus.ID          = id;
        bus.state_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.state_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.state_valid = 1'b0;
    endtask

    // Sink one packet with pct% ready; records words, TLAST flags and stall violations
    task automatic collect(input int pct, input int budget);
        bit          stalled;
        bit          done;
        bit          rdy;
        logic [15:0] held_data;
        logic        held_last;
        got_words.delete();
        got_last.delete();
        stab_err  = 0;
        timed_out = 1'b0;
        stalled   = 1'b0;
        done      = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        for (int c = 0; !done; c++) begin
            if (c >= budget) begin
                timed_out = 1'b1;
                break;
            end
            rdy = ($urandom_range(99) < pct);
            bus.M_TREADY = rdy;
            if (bus.M_TVALID) begin
                if (stalled && (bus.M_TDATA !== held_data || bus.M_TLAST !== held_last))
                    stab_err++;
                if (rdy) begin
                    got_words.push_back(bus.M_TDATA);
                    got_last.push_back(bus.M_TLAST);
                    done    = (bus.M_TLAST === 1'b1);
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = bus.M_TDATA;
                    held_last = bus.M_TLAST;
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Compares collected packet against exp_words, including TLAST placement
    task automatic check_packet(input string name);
        int mism;
        int nlast;
        int lastpos;
        mism = 0; nlast = 0; lastpos = -1;
        for (int i = 0; i < got_words.size() && i < exp_words.size(); i++)
            if (got_words[i] !== exp_words[i]) mism++;
        for (int i = 0; i < got_last.size(); i++)
            if (got_last[i]) begin nlast++; lastpos = i; end
        checks++;
        if (timed_out || got_words.size() != exp_words.size() || mism != 0) begin
            errors++;
            $display("FAIL %s words: got %0d words (%0d wrong, timeout=%0d), expected %0d",
                     name, got_words.size(), mism, timed_out, exp_words.size());
        end
        checks++;
        if (nlast != 1 || lastpos != exp_words.size() - 1) begin
            errors++;
            $display("FAIL %s tlast: got %0d TLASTs, last at word %0d, expected one at word %0d",
                     name, nlast, lastpos + 1, exp_words.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.state_ready !== 1'b0 || bus.M_TVALID !== 1'b0 || bus.M_TLAST !== 1'b0 ||
            bus.busy !== 1'b0 || bus.M_TDATA !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b last=%b busy=%b data=%h, expected all 0",
                     bus.state_ready, bus.M_TVALID, bus.M_TLAST, bus.busy, bus.M_TDATA);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state_ready !== 1'b1 || bus.M_TVALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b, expected ready=1 valid=0",
                     bus.state_ready, bus.M_TVALID);
        end
    endtask

    task automatic test_known_vector();
        keccak_state_t st;
        bit            ok;
        logic [255:0]  cat;
        st = rand_state();
        st[0][0] = 64'h66d71ebff8c6ffa7;
        st[1][0] = 64'h62d661a05647c151;
        st[2][0] = 64'hfa493be44dff80f5;
        st[3][0] = 64'h4a43f8804b0ad882;
        make_expected(st, 1);
        send_state(st, 2'd1, ok);
        checks++;
        if (!ok || bus.M_TVALID !== 1'b1 || bus.busy !== 1'b1 || bus.state_ready !== 1'b0) begin
            errors++;
            $display("FAIL kv_latency: got ok=%0d valid=%b busy=%b ready=%b, expected 1 1 1 0",
                     ok, bus.M_TVALID, bus.busy, bus.state_ready);
        end
        collect(100, 200);
        check_packet("kv");
        checks++;
        if (got_words.size() < 2 || got_words[0] !== 16'ha7ff || got_words[1] !== 16'hc6f8) begin
            errors++;
            $display("FAIL kv_first_words: got %0d words starting %h %h, expected a7ff c6f8",
                     got_words.size(), got_words.size() > 0 ? got_words[0] : 16'hx,
                     got_words.size() > 1 ? got_words[1] : 16'hx);
        end
        cat = '0;
        foreach (got_words[i]) cat = {cat[239:0], got_words[i]};
        checks++;
        if (cat !== 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a) begin
            errors++;
            $display("FAIL kv_digest: got %h, expected a7ffc6f8...80f8434a", cat);
        end
        checks++;
        if (bus.state_ready !== 1'b1 || bus.M_TVALID !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL kv_return_idle: got ready=%b valid=%b busy=%b, expected 1 0 0",
                     bus.state_ready, bus.M_TVALID, bus.busy);
        end
    endtask

    task automatic test_modes();
        keccak_state_t st;
        bit            ok;
        for (int id = 0; id < 4; id++) begin
            st = rand_state();
            make_expected(st, id);
            send_state(st, 2'(id), ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL mode%0d_accept: got no accept, expected accept", id);
            end
            collect(100, 200);
            check_packet($sformatf("mode%0d", id));
        end
    endtask

    task automatic test_backpressure();
        keccak_state_t st;
        bit            ok;
        int            id;
        logic [15:0]   ref_words[$];
        for (int it = 0; it < 3; it++) begin
            st = rand_state();
            id = int'($urandom_range(3));
            make_expected(st, id);
            send_state(st, 2'(id), ok);
            collect(100, 200);
            ref_words = got_words;
            send_state(st, 2'(id), ok);
            collect(50, 3000);
            check_packet($sformatf("bp%0d", it));
            checks++;
            if (stab_err != 0 || got_words != ref_words) begin
                errors++;
                $display("FAIL bp%0d_stall: got %0d stall violations, same_as_nostall=%0d, expected 0 and 1",
                         it, stab_err, got_words == ref_words);
            end
        end
    endtask

    task automatic test_ignore_valid();
        keccak_state_t st_a;
        bit            ok;
        st_a = rand_state();
        make_expected(st_a, 1);
        bus.M_TREADY = 1'b0;
        send_state(st_a, 2'd1, ok);
        bus.state_in    = rand_state();
        bus.ID          = 2'd3;
        bus.state_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.state_ready !== 1'b0 || bus.M_TDATA !== exp_words[0] || bus.M_TVALID !== 1'b1) begin
            errors++;
            $display("FAIL ignore_hold: got ready=%b valid=%b data=%h, expected 0 1 %h",
                     bus.state_ready, bus.M_TVALID, bus.M_TDATA, exp_words[0]);
        end
        bus.state_valid = 1'b0;
        collect(100, 200);
        check_packet("ignore");
    endtask

    task automatic test_reset_mid();
        keccak_state_t st;
        bit            ok;
        int            stray;
        st = rand_state();
        make_expected(st, 3);
        send_state(st, 2'd3, ok);
        bus.M_TREADY = 1'b1;
        repeat (5) @(negedge clk);
        bus.M_TREADY = 1'b0;
        checks++;
        if (bus.M_TDATA !== exp_words[5]) begin
            errors++;
            $display("FAIL rstmid_word5: got %h, expected %h", bus.M_TDATA, exp_words[5]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.M_TVALID !== 1'b0 || bus.M_TLAST !== 1'b0 || bus.busy !== 1'b0 ||
            bus.state_ready !== 1'b0 || bus.M_TDATA !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_async: got valid=%b last=%b busy=%b ready=%b data=%h, expected all 0",
                     bus.M_TVALID, bus.M_TLAST, bus.busy, bus.state_ready, bus.M_TDATA);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.M_TREADY = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.M_TVALID !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0 || bus.state_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_abort: got %0d stray valid cycles, ready=%b, expected 0 and 1",
                     stray, bus.state_ready);
        end
        st = rand_state();
        make_expected(st, 0);
        send_state(st, 2'd0, ok);
        collect(100, 200);
        check_packet("rstmid_restart");
    endtask

    task automatic test_back_to_back();
        keccak_state_t st_a;
        keccak_state_t st_b;
        st_a = rand_state();
        st_b = rand_state();
        bus.M_TREADY    = 1'b1;
        bus.state_in    = st_a;
        bus.ID          = 2'd0;
        bus.state_valid = 1'b1;
        @(negedge clk);
        bus.state_in = st_b;
        bus.ID       = 2'd2;
        make_expected(st_a, 0);
        collect(100, 200);
        check_packet("b2b_first");
        checks++;
        if (bus.state_ready !== 1'b1 || bus.M_TVALID !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready: got ready=%b valid=%b, expected 1 0", bus.state_ready, bus.M_TVALID);
        end
        @(negedge clk);
        checks++;
        if (bus.state_ready !== 1'b0 || bus.M_TVALID !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got ready=%b valid=%b, expected 0 1", bus.state_ready, bus.M_TVALID);
        end
        bus.state_valid = 1'b0;
        make_expected(st_b, 2);
        collect(100, 200);
        check_packet("b2b_second");
    endtask

    initial begin
        rst             = 1'b1;
        bus.state_in    = '0;
        bus.state_valid = 1'b0;
        bus.ID          = 2'd0;
        bus.M_TREADY    = 1'b0;
        test_reset();
        test_known_vector();
        test_modes();
        test_backpressure();
        test_ignore_valid();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha_digest_tx.md
SHA_DIGEST_TX -- requirements
Module: sha_digest_tx

Interface
REQ-001 ACLK  input  1  sole clock; all state updates on rising edge.
REQ-002 ARESET  input  1  asynchronous, active-high reset.
REQ-003 state_in  input  [0:4][0:4][63:0]  final Keccak state, lane A[x][y] = state_in[x][y].
REQ-004 state_valid  input  1  state_in and ID are valid this cycle.
REQ-005 state_ready  output  1  block can accept a new state (high only in IDLE).
REQ-006 ID  input  2  digest mode: 0 = SHA3-224, 1 = SHA3-256, 2 = SHA3-384, 3 = SHA3-512.
REQ-007 M_TDATA  output  16  digest word.
REQ-008 M_TVALID  output  1  M_TDATA is valid.
REQ-009 M_TREADY  input  1  downstream accepts the word.
REQ-010 M_TLAST  output  1  marks the final digest word.
REQ-011 busy  output  1  high while a digest is being transmitted.

Function
REQ-012 FSM SHALL have two states: IDLE (state_ready=1, M_TVALID=0) and SEND (state_ready=0, M_TVALID=1, busy=1).
REQ-013 Accept condition: state_valid && state_ready; in that cycle the FSM latches lanes 0..7 (A[0][0], A[1][0], A[2][0], A[3][0], A[4][0], A[0][1], A[1][1], A[2][1]; 512 bits), latches ID, clears the word counter, and moves to SEND.
REQ-014 The first M_TVALID SHALL assert on the cycle after the accept cycle (latency 1).
REQ-015 Word count N from latched ID: 224->14, 256->16, 384->24, 512->32 words.
REQ-016 Word k (0..N-1): lane L = k/4, byte b = 2*(k%4); M_TDATA = {lane[8b+7:8b], lane[8b+15:8b+8]}, so concatenated words form the standard big-endian hex digest.
REQ-017 Transfer occurs on M_TVALID && M_TREADY; the counter increments only on a transfer.
REQ-018 While M_TVALID && !M_TREADY, M_TDATA and M_TLAST SHALL hold stable.
REQ-019 M_TLAST = 1 exactly when in SEND and counter == N-1.
REQ-020 A transfer with M_TLAST=1 returns the FSM to IDLE; state_ready is 1 on the next cycle, with no bubble beyond that.
REQ-021 state_valid while in SEND SHALL be ignored; the latched buffer and ID SHALL not change.
REQ-022 Latched ID governs the whole packet; ID changes after accept SHALL have no effect.
REQ-023 Counter width is 5 bits; it never exceeds N-1 and never wraps within a packet.

Reset
REQ-024 ARESET asserted SHALL immediately force: FSM=IDLE, counter=0, M_TVALID=0, M_TLAST=0, busy=0, state_ready=0 while ARESET is high, M_TDATA=0, buffer=0, latched ID=0.
REQ-025 ARESET mid-packet SHALL abort the packet; no further words SHALL be sent for it after release.
REQ-026 state_ready SHALL rise the first clock edge after ARESET deasserts.

Structure
REQ-027 Shared package sha3_pkg SHALL hold the mode enum (SHA3_224..SHA3_512), the word-count constants per mode (14/16/24/32), WIDTH=16, and the digest-lane index table.
REQ-028 One sub-module, sha_word_sel, SHALL be purely combinational: it takes the 512-bit buffer and the counter and returns the byte-swapped 16-bit word.

Verification
REQ-029 SHA3-256 empty-message state (lane0=64'h66d71ebff8c6ffa7, lanes 1-3 per the standard digest), ID=1, M_TREADY=1 -> 16 words, first a7ff then c6f8, TLAST on word 16, concatenation = a7ffc6f8...80f8434a.
REQ-030 ID=0 -> exactly 14 words, TLAST only on word 14; ID=3 -> 32 words, TLAST only on word 32; ID=2 -> 24 words.
REQ-031 Random M_TREADY backpressure (50%) -> M_TDATA/M_TLAST stable during stalls, word sequence identical to the no-stall run.
REQ-032 state_valid pulsed with a different state_in and ID=3 during SEND -> ignored; the original 16-word packet completes unchanged.
REQ-033 ARESET pulse after word 5 -> M_TVALID=0 immediately; after release, state_ready=1 and a new accept restarts at word 0.
REQ-034 Back-to-back: state_valid held high, TLAST transfer -> new state accepted the cycle after state_ready rises, first word valid one cycle later.
